// File: rtl/aq_djpeg_fbwr_pkg.sv
// Shared constants and payload types for the djpeg frame-buffer writer.
//   PIX_BYTES : bytes occupied by one pixel in the frame buffer
//   WR_PAD    : filler byte placed above RGB in each write word
//   pix_t     : one decoded pixel as carried through the pixel FIFO
package aq_djpeg_fbwr_pkg;

    localparam int unsigned PIX_BYTES = 4;
    localparam logic [7:0]  WR_PAD    = 8'h00;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
    } pix_t;

    localparam int unsigned PIX_W = $bits(pix_t);

endpackage

// File: rtl/aq_djpeg_fbwr_fifo.sv
// Synchronous FIFO, first-word-fall-through head.
//   clk, rst          : clock, synchronous active-high reset
//   push, push_data   : write request (ignored when full)
//   pop               : consume head (ignored when empty)
//   head_data         : current head entry
//   full, empty       : occupancy flags (from registered count)
module aq_djpeg_fbwr_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign head_data = mem_q[rd_ptr_q];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    // Pointer/count update; depth is a power of two so pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/aq_djpeg_fbwr.sv
// Frame-buffer writer: buffers decoded pixels and turns each into one
// 32-bit memory write at Base + Y*Stride + X*4.
//   clk, rst                          : clock, synchronous active-high reset
//   FrameStart, FrameBase, FrameStride,
//   PixWidth, PixHeight               : frame configuration, sampled on FrameStart
//   PixEnable/PixReady, PixX/Y/R/G/B  : pixel input stream
//   WrValid/WrReady, WrAddr, WrData   : memory write request channel
//   Busy, FrameDone, PixCount         : status
module aq_djpeg_fbwr
    import aq_djpeg_fbwr_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        FrameStart,
    input  logic [31:0] FrameBase,
    input  logic [15:0] FrameStride,
    input  logic [15:0] PixWidth,
    input  logic [15:0] PixHeight,
    input  logic        PixEnable,
    output logic        PixReady,
    input  logic [15:0] PixX,
    input  logic [15:0] PixY,
    input  logic [7:0]  PixR,
    input  logic [7:0]  PixG,
    input  logic [7:0]  PixB,
    output logic        WrValid,
    input  logic        WrReady,
    output logic [31:0] WrAddr,
    output logic [31:0] WrData,
    output logic        Busy,
    output logic        FrameDone,
    output logic [31:0] PixCount
);

    pix_t        push_pix, head_pix;
    logic        fifo_full, fifo_empty;
    logic        push, load, xfer, last_pix;

    logic [31:0] cfg_base_q, cfg_base_d;
    logic [15:0] cfg_stride_q, cfg_stride_d;
    logic [15:0] cfg_w_q, cfg_w_d;
    logic [15:0] cfg_h_q, cfg_h_d;
    logic        wr_valid_q, wr_valid_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [15:0] cur_x_q, cur_x_d;
    logic [15:0] cur_y_q, cur_y_d;
    logic [31:0] pix_count_q, pix_count_d;
    logic        frame_done_q, frame_done_d;

    always_comb begin
        push_pix.x = PixX;
        push_pix.y = PixY;
        push_pix.r = PixR;
        push_pix.g = PixG;
        push_pix.b = PixB;
    end

    aq_djpeg_fbwr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_pix),
        .pop       (load),
        .head_data (head_pix),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // A full FIFO refuses input even if the head is leaving this cycle.
    assign PixReady  = !fifo_full;
    assign push      = PixEnable && !fifo_full;
    assign xfer      = wr_valid_q && WrReady;
    assign load      = !fifo_empty && (!wr_valid_q || WrReady);
    assign last_pix  = (cfg_w_q != 16'd0) && (cfg_h_q != 16'd0) &&
                       (cur_x_q == cfg_w_q - 16'd1) && (cur_y_q == cfg_h_q - 16'd1);

    assign WrValid   = wr_valid_q;
    assign WrAddr    = wr_addr_q;
    assign WrData    = wr_data_q;
    assign PixCount  = pix_count_q;
    assign FrameDone = frame_done_q;
    assign Busy      = !fifo_empty || wr_valid_q;

    // Output stage, status counters and configuration capture.
    always_comb begin
        cfg_base_d   = cfg_base_q;
        cfg_stride_d = cfg_stride_q;
        cfg_w_d      = cfg_w_q;
        cfg_h_d      = cfg_h_q;
        wr_valid_d   = wr_valid_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        pix_count_d  = pix_count_q;
        frame_done_d = 1'b0;

        if (load) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = cfg_base_q
                       + 32'(head_pix.y) * 32'(cfg_stride_q)
                       + 32'(head_pix.x) * PIX_BYTES;
            wr_data_d  = {WR_PAD, head_pix.r, head_pix.g, head_pix.b};
            cur_x_d    = head_pix.x;
            cur_y_d    = head_pix.y;
        end else if (xfer) begin
            wr_valid_d = 1'b0;
        end

        if (xfer) begin
            pix_count_d  = pix_count_q + 32'd1;
            frame_done_d = last_pix;
        end

        // New frame config; counter restart overrides a coincident transfer.
        if (FrameStart) begin
            cfg_base_d   = FrameBase;
            cfg_stride_d = FrameStride;
            cfg_w_d      = PixWidth;
            cfg_h_d      = PixHeight;
            pix_count_d  = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_base_q   <= '0;
            cfg_stride_q <= '0;
            cfg_w_q      <= '0;
            cfg_h_q      <= '0;
            wr_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            pix_count_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cfg_base_q   <= cfg_base_d;
            cfg_stride_q <= cfg_stride_d;
            cfg_w_q      <= cfg_w_d;
            cfg_h_q      <= cfg_h_d;
            wr_valid_q   <= wr_valid_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            pix_count_q  <= pix_count_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_aq_djpeg_fbwr.sv
// Self-checking bench for aq_djpeg_fbwr: directed scenarios with randomized
// pixel data, checked against a queue-based reference model.
module tb_aq_djpeg_fbwr;

    logic        clk = 1'b0;
    logic        rst;
    logic        FrameStart;
    logic [31:0] FrameBase;
    logic [15:0] FrameStride, PixWidth, PixHeight;
    logic        PixEnable, PixReady;
    logic [15:0] PixX, PixY;
    logic [7:0]  PixR, PixG, PixB;
    logic        WrValid, WrReady;
    logic [31:0] WrAddr, WrData;
    logic        Busy, FrameDone;
    logic [31:0] PixCount;

    aq_djpeg_fbwr #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .FrameStart(FrameStart), .FrameBase(FrameBase),
        .FrameStride(FrameStride), .PixWidth(PixWidth), .PixHeight(PixHeight),
        .PixEnable(PixEnable), .PixReady(PixReady), .PixX(PixX), .PixY(PixY),
        .PixR(PixR), .PixG(PixG), .PixB(PixB), .WrValid(WrValid), .WrReady(WrReady),
        .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy), .FrameDone(FrameDone),
        .PixCount(PixCount)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          x;
        int          y;
    } exp_t;

    exp_t        m_q[$];
    logic [31:0] m_cnt = 32'd0;
    bit          m_done = 1'b0;
    longint      c_base = 0, c_stride = 0;
    int          c_w = 0, c_h = 0;
    bit          mon_en = 1'b0;
    bit          hold_prev = 1'b0;
    logic [31:0] prev_addr, prev_data;
    int          n_writes = 0;
    int          done_pulses = 0;

    // Inputs change at posedge+1, so the negedge sees exactly what the next edge takes.
    always @(negedge clk) begin
        exp_t   e;
        longint a;
        if (mon_en) begin
            check("pixcount", PixCount, m_cnt);
            check("framedone", 32'(FrameDone), 32'(m_done));
            check("busy", 32'(Busy), 32'(m_q.size() != 0));
            if (hold_prev) begin
                check("hold_valid", 32'(WrValid), 32'd1);
                check("hold_addr", WrAddr, prev_addr);
                check("hold_data", WrData, prev_data);
            end
            if (FrameDone) done_pulses++;
        end
        hold_prev = WrValid && !WrReady && !rst;
        prev_addr = WrAddr;
        prev_data = WrData;
        if (rst) begin
            m_q.delete();
            m_cnt  = 32'd0;
            m_done = 1'b0;
            c_base = 0; c_stride = 0; c_w = 0; c_h = 0;
        end else begin
            m_done = 1'b0;
            if (WrValid && WrReady) begin
                n_tests++;
                assert (m_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_write: observed write to %h, expected none pending", WrAddr);
                end
                if (m_q.size() != 0) begin
                    e = m_q.pop_front();
                    check("wr_addr", WrAddr, e.addr);
                    check("wr_data", WrData, e.data);
                    m_done = (c_w > 0) && (c_h > 0) && (e.x == c_w - 1) && (e.y == c_h - 1);
                end
                n_writes++;
                if (!FrameStart) m_cnt = m_cnt + 32'd1;
            end
            if (FrameStart) begin
                c_base   = longint'(FrameBase);
                c_stride = longint'(FrameStride);
                c_w      = int'(PixWidth);
                c_h      = int'(PixHeight);
                m_cnt    = 32'd0;
            end
            if (PixEnable && PixReady) begin
                a      = c_base + longint'(PixY) * c_stride + longint'(PixX) * 4;
                e.addr = 32'(a);
                e.data = {8'h00, PixR, PixG, PixB};
                e.x    = int'(PixX);
                e.y    = int'(PixY);
                m_q.push_back(e);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y);
        PixX = 16'(x);
        PixY = 16'(y);
        PixR = 8'($urandom);
        PixG = 8'($urandom);
        PixB = 8'($urandom);
    endtask

    task automatic frame_start(input logic [31:0] base, input logic [15:0] stride,
                               input logic [15:0] w, input logic [15:0] h);
        FrameStart = 1'b1; FrameBase = base; FrameStride = stride;
        PixWidth = w; PixHeight = h;
        tick();
        FrameStart = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 400; i++) begin
            if (!Busy) break;
            tick();
        end
        check(tag, 32'(Busy), 32'd0);
    endtask

    // Offer up to n pixels with random coords while PixReady stays high; returns count accepted.
    task automatic offer(input int n, output int acc);
        acc = 0;
        for (int c = 0; c < 40 && acc < n; c++) begin
            if (!PixReady) break;
            set_pix($urandom_range(639), $urandom_range(479));
            PixEnable = 1'b1;
            tick();
            acc++;
        end
        PixEnable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, w0, stalls, idx, guard;
        bit en;

        rst = 1'b1; FrameStart = 1'b0; FrameBase = '0; FrameStride = '0;
        PixWidth = '0; PixHeight = '0; PixEnable = 1'b0; WrReady = 1'b0;
        PixX = '0; PixY = '0; PixR = '0; PixG = '0; PixB = '0;
        tick(); tick();
        check("rst_wrvalid",  32'(WrValid), 32'd0);
        check("rst_wraddr",   WrAddr, 32'd0);
        check("rst_wrdata",   WrData, 32'd0);
        check("rst_pixcount", PixCount, 32'd0);
        check("rst_framedone", 32'(FrameDone), 32'd0);
        check("rst_busy",     32'(Busy), 32'd0);
        check("rst_pixready", 32'(PixReady), 32'd1);
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic address/data and two-edge latency.
        frame_start(32'h1000_0000, 16'h0A00, 16'd640, 16'd480);
        WrReady = 1'b1;
        PixX = 16'd3; PixY = 16'd2; PixR = 8'h11; PixG = 8'h22; PixB = 8'h33;
        PixEnable = 1'b1;
        tick();
        PixEnable = 1'b0;
        check("lat_edge1_valid", 32'(WrValid), 32'd0);
        tick();
        check("lat_edge2_valid", 32'(WrValid), 32'd1);
        check("basic_addr", WrAddr, 32'h1000_140C);
        check("basic_data", WrData, 32'h0011_2233);
        tick();
        check("basic_done_valid", 32'(WrValid), 32'd0);
        check("basic_count", PixCount, 32'd1);

        // Backpressure: FIFO plus output register absorb five pixels.
        frame_start(32'h1000_0000, 16'h0A00, 16'd640, 16'd480);
        WrReady = 1'b0;
        w0 = n_writes;
        offer(6, acc);
        check("stall_accepted", 32'(acc), 32'd5);
        check("stall_pixready", 32'(PixReady), 32'd0);
        check("stall_wrvalid", 32'(WrValid), 32'd1);
        WrReady = 1'b1;
        wait_idle("stall_drain");
        check("stall_writes", 32'(n_writes - w0), 32'd5);
        check("stall_count", PixCount, 32'd5);

        // Full 16x8 frame in raster order with random gaps and backpressure.
        frame_start(32'($urandom) & 32'hFFFF_FFFC, 16'd64, 16'd16, 16'd8);
        w0 = done_pulses;
        idx = 0; guard = 0;
        while (idx < 128 && guard < 3000) begin
            en = ($urandom_range(2) != 0);
            set_pix(idx % 16, idx / 16);
            PixEnable = en;
            WrReady = ($urandom_range(3) != 0);
            if (en && PixReady) idx++;
            tick();
            guard++;
        end
        PixEnable = 1'b0;
        WrReady = 1'b1;
        check("frame_all_sent", 32'(idx), 32'd128);
        wait_idle("frame_drain");
        tick(); tick();
        check("frame_count", PixCount, 32'd128);
        check("frame_done_pulses", 32'(done_pulses - w0), 32'd1);

        // Zero width: last-pixel match must never fire.
        frame_start(32'h0000_2000, 16'd64, 16'd0, 16'd8);
        w0 = done_pulses;
        set_pix(16'hFFFF, 7);
        PixEnable = 1'b1;
        tick();
        PixEnable = 1'b0;
        wait_idle("zero_w_drain");
        tick(); tick();
        check("zero_w_no_done", 32'(done_pulses - w0), 32'd0);

        // Address wrap modulo 2^32.
        frame_start(32'hFFFF_FFF0, 16'd16, 16'd640, 16'd480);
        PixX = 16'd5; PixY = 16'd0; PixR = 8'hAA; PixG = 8'hBB; PixB = 8'hCC;
        PixEnable = 1'b1;
        tick();
        PixEnable = 1'b0;
        tick();
        check("wrap_addr", WrAddr, 32'h0000_0004);
        check("wrap_data", WrData, 32'h00AA_BBCC);
        wait_idle("wrap_drain");

        // Sustained one pixel per clock with WrReady held high.
        w0 = n_writes;
        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            if (!PixReady) stalls++;
            set_pix(i, 1);
            PixEnable = 1'b1;
            tick();
        end
        PixEnable = 1'b0;
        tick(); tick();
        check("tput_stalls", 32'(stalls), 32'd0);
        check("tput_writes", 32'(n_writes - w0), 32'd8);
        check("tput_idle", 32'(Busy), 32'd0);

        // FrameStart coinciding with a transfer: counter restarts, data still written.
        frame_start(32'h0004_0000, 16'd2560, 16'd640, 16'd480);
        WrReady = 1'b0;
        offer(3, acc);
        check("fs_xfer_accepted", 32'(acc), 32'd3);
        check("fs_xfer_valid", 32'(WrValid), 32'd1);
        w0 = n_writes;
        WrReady = 1'b1;
        FrameStart = 1'b1;
        tick();
        FrameStart = 1'b0;
        check("fs_xfer_count0", PixCount, 32'd0);
        wait_idle("fs_xfer_drain");
        check("fs_xfer_writes", 32'(n_writes - w0), 32'd3);
        check("fs_xfer_count", PixCount, 32'd2);

        // Reset mid-operation with three queued entries and a pending write.
        WrReady = 1'b0;
        offer(4, acc);
        check("rst_mid_accepted", 32'(acc), 32'd4);
        check("rst_mid_valid", 32'(WrValid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_wrvalid", 32'(WrValid), 32'd0);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        check("rst_mid_pixready", 32'(PixReady), 32'd1);
        check("rst_mid_pixcount", PixCount, 32'd0);
        w0 = n_writes;
        WrReady = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("rst_mid_no_writes", 32'(n_writes - w0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
